countup_timer: RTL and testbench

//   Synchronous BCD hh:mm:ss up-counting elapsed-time timer (stopwatch): the

---
 rtl/countup_timer_pkg.sv | 33 +++
 rtl/countup_timer_bcd2_inc.sv | 28 ++
 rtl/countup_timer.sv | 147 ++++++++++++++
 tb/tb_countup_timer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/countup_timer_pkg.sv
// Shared definitions for the BCD hh:mm:ss count-up timer.
package countup_timer_pkg;

    localparam int unsigned BCD_W = 8;

    localparam logic [BCD_W-1:0] MOD_60 = 8'h59;
    localparam logic [BCD_W-1:0] MOD_24 = 8'h23;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Both nibbles are decimal digits.
    function automatic logic bcd_digits_ok(input logic [BCD_W-1:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // Valid BCD and not above the field terminal value (BCD order equals binary order).
    function automatic logic bcd_in_range(input logic [BCD_W-1:0] v,
                                          input logic [BCD_W-1:0] max);
        return bcd_digits_ok(v) && (v <= max);
    endfunction

    // Out-of-range load values collapse to zero.
    function automatic logic [BCD_W-1:0] bcd_sanitize(input logic [BCD_W-1:0] v,
                                                      input logic [BCD_W-1:0] max);
        return bcd_in_range(v, max) ? v : 8'h00;
    endfunction

endpackage

// File: rtl/countup_timer_bcd2_inc.sv
// Combinational two-digit BCD incrementer with terminal value and carry.
module countup_timer_bcd2_inc
    import countup_timer_pkg::*;
(
    input  logic [7:0] value_i,
    input  logic [7:0] max_i,
    input  logic       cin_i,
    output logic [7:0] next_o,
    output logic       cout_o
);

    // Hold without carry-in; wrap to 00 at the terminal value; else +1 with digit carry.
    always_comb begin
        next_o = value_i;
        cout_o = 1'b0;
        if (cin_i) begin
            if (value_i == max_i) begin
                next_o = 8'h00;
                cout_o = 1'b1;
            end else if (value_i[3:0] == 4'd9) begin
                next_o = {4'(value_i[7:4] + 4'd1), 4'd0};
            end else begin
                next_o = {value_i[7:4], 4'(value_i[3:0] + 4'd1)};
            end
        end
    end

endmodule

// File: rtl/countup_timer.sv
// BCD hh:mm:ss stopwatch: counts CE ticks while running, flags reaching a limit.
module countup_timer
    import countup_timer_pkg::*;
#(
    parameter logic [7:0] HOUR_MAX = MOD_24,
    parameter logic [7:0] MIN_MAX  = MOD_60,
    parameter logic [7:0] SEC_MAX  = MOD_60
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       CE,
    input  logic       START,
    input  logic       STOP,
    input  logic       PE,
    input  logic [7:0] D_H,
    input  logic [7:0] D_M,
    input  logic [7:0] D_S,
    input  logic [7:0] LIM_H,
    input  logic [7:0] LIM_M,
    input  logic [7:0] LIM_S,
    output logic [7:0] Q_H,
    output logic [7:0] Q_M,
    output logic [7:0] Q_S,
    output logic       RUN,
    output logic       TC,
    output logic       DONE
);

    state_e     state_q;
    logic [7:0] cnt_h_q, cnt_m_q, cnt_s_q;
    logic       run_q, tc_q, done_q;

    logic [7:0] inc_h_d, inc_m_d, inc_s_d;
    logic       carry_s, carry_m;
    logic       unused_hour_cout;

    logic [7:0] ld_h, ld_m, ld_s;
    logic       lim_ok, lim_match;

    // Seconds -> minutes -> hours carry chain, resolved in one cycle.
    countup_timer_bcd2_inc u_inc_s (
        .value_i (cnt_s_q),
        .max_i   (SEC_MAX),
        .cin_i   (1'b1),
        .next_o  (inc_s_d),
        .cout_o  (carry_s)
    );

    countup_timer_bcd2_inc u_inc_m (
        .value_i (cnt_m_q),
        .max_i   (MIN_MAX),
        .cin_i   (carry_s),
        .next_o  (inc_m_d),
        .cout_o  (carry_m)
    );

    countup_timer_bcd2_inc u_inc_h (
        .value_i (cnt_h_q),
        .max_i   (HOUR_MAX),
        .cin_i   (carry_m),
        .next_o  (inc_h_d),
        .cout_o  (unused_hour_cout)
    );

    // Load sanitising and limit match on the incremented value.
    always_comb begin
        ld_h      = bcd_sanitize(D_H, HOUR_MAX);
        ld_m      = bcd_sanitize(D_M, MIN_MAX);
        ld_s      = bcd_sanitize(D_S, SEC_MAX);
        lim_ok    = bcd_in_range(LIM_H, HOUR_MAX) &&
                    bcd_in_range(LIM_M, MIN_MAX)  &&
                    bcd_in_range(LIM_S, SEC_MAX);
        lim_match = lim_ok && ({inc_h_d, inc_m_d, inc_s_d} == {LIM_H, LIM_M, LIM_S});
    end

    // Control FSM and count registers; priority PE > STOP > START > tick.
    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            state_q <= ST_IDLE;
            cnt_h_q <= 8'h00;
            cnt_m_q <= 8'h00;
            cnt_s_q <= 8'h00;
            run_q   <= 1'b0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            if (PE) begin
                cnt_h_q <= ld_h;
                cnt_m_q <= ld_m;
                cnt_s_q <= ld_s;
                state_q <= ST_IDLE;
                run_q   <= 1'b0;
                done_q  <= 1'b0;
            end else if (STOP && (state_q != ST_IDLE)) begin
                // STOP has no effect in IDLE, so a concurrent START still applies there.
                unique case (state_q)
                    ST_RUN: begin
                        state_q <= ST_PAUSE;
                        run_q   <= 1'b0;
                    end
                    ST_PAUSE: begin
                        state_q <= ST_IDLE;
                        cnt_h_q <= 8'h00;
                        cnt_m_q <= 8'h00;
                        cnt_s_q <= 8'h00;
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end else if (START) begin
                // A START edge never advances the count, even with CE present.
                if (state_q == ST_DONE) begin
                    cnt_h_q <= 8'h00;
                    cnt_m_q <= 8'h00;
                    cnt_s_q <= 8'h00;
                end
                state_q <= ST_RUN;
                run_q   <= 1'b1;
                done_q  <= 1'b0;
            end else if ((state_q == ST_RUN) && CE) begin
                cnt_h_q <= inc_h_d;
                cnt_m_q <= inc_m_d;
                cnt_s_q <= inc_s_d;
                if (lim_match) begin
                    tc_q    <= 1'b1;
                    state_q <= ST_DONE;
                    run_q   <= 1'b0;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    assign Q_H  = cnt_h_q;
    assign Q_M  = cnt_m_q;
    assign Q_S  = cnt_s_q;
    assign RUN  = run_q;
    assign TC   = tc_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_countup_timer.sv
// Scoreboard bench for countup_timer against a seconds-based reference model.
module tb_countup_timer;

    localparam int DAY = 86400;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic       CP = 1'b0;
    logic       CR, CE, START, STOP, PE;
    logic [7:0] D_H, D_M, D_S, LIM_H, LIM_M, LIM_S;
    logic [7:0] Q_H, Q_M, Q_S;
    logic       RUN, TC, DONE;

    always #5 CP = ~CP;

    countup_timer dut (
        .CP(CP), .CR(CR), .CE(CE), .START(START), .STOP(STOP), .PE(PE),
        .D_H(D_H), .D_M(D_M), .D_S(D_S),
        .LIM_H(LIM_H), .LIM_M(LIM_M), .LIM_S(LIM_S),
        .Q_H(Q_H), .Q_M(Q_M), .Q_S(Q_S),
        .RUN(RUN), .TC(TC), .DONE(DONE)
    );

    typedef struct {
        logic [7:0] h, m, s;
        logic       run, tc, done;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: elapsed seconds within a day plus a symbolic mode.
    int m_secs  = 0;
    int m_state = M_IDLE;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    // Decimal value of a BCD field, or -1 when not a legal field value.
    function automatic int field_val(input logic [7:0] b, input int maxv);
        int hi, lo;
        hi = int'(b[7:4]);
        lo = int'(b[3:0]);
        if (hi > 9 || lo > 9) return -1;
        if (hi * 10 + lo > maxv) return -1;
        return hi * 10 + lo;
    endfunction

    function automatic int san(input logic [7:0] b, input int maxv);
        int v;
        v = field_val(b, maxv);
        return (v < 0) ? 0 : v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    function automatic exp_t model_out(input logic tc);
        exp_t e;
        e.h    = to_bcd(m_secs / 3600);
        e.m    = to_bcd((m_secs / 60) % 60);
        e.s    = to_bcd(m_secs % 60);
        e.run  = (m_state == M_RUN);
        e.tc   = tc;
        e.done = (m_state == M_DONE);
        return e;
    endfunction

    // Drive one edge worth of inputs and queue the model's response to it.
    task automatic cycle(input logic pe, input logic stop, input logic start, input logic ce,
                         input logic [23:0] d, input logic [23:0] lim);
        int  lh, lm, ls, lim_secs;
        logic tc;
        @(negedge CP);
        PE = pe; STOP = stop; START = start; CE = ce;
        {D_H, D_M, D_S}       = d;
        {LIM_H, LIM_M, LIM_S} = lim;
        lh = field_val(lim[23:16], 23);
        lm = field_val(lim[15:8], 59);
        ls = field_val(lim[7:0], 59);
        lim_secs = (lh < 0 || lm < 0 || ls < 0) ? -1 : lh * 3600 + lm * 60 + ls;
        tc = 1'b0;
        if (pe) begin
            m_secs  = san(d[23:16], 23) * 3600 + san(d[15:8], 59) * 60 + san(d[7:0], 59);
            m_state = M_IDLE;
        end else if (stop && m_state != M_IDLE) begin
            if (m_state == M_RUN) m_state = M_PAUSE;
            else if (m_state == M_PAUSE) begin m_state = M_IDLE; m_secs = 0; end
            else m_state = M_IDLE;
        end else if (start) begin
            if (m_state == M_DONE) m_secs = 0;
            m_state = M_RUN;
        end else if (m_state == M_RUN && ce) begin
            m_secs = (m_secs + 1) % DAY;
            if (m_secs == lim_secs) begin
                tc = 1'b1;
                m_state = M_DONE;
            end
        end
        exp_q.push_back(model_out(tc));
    endtask

    // Mid-cycle asynchronous clear, checked immediately and at the following edge.
    task automatic cr_pulse();
        @(negedge CP);
        PE = 1'b0; STOP = 1'b0; START = 1'b0; CE = 1'b0;
        #2;
        CR = 1'b1;
        #1;
        check("async_clr_Q", {8'h0, Q_H, Q_M, Q_S}, 32'h0);
        check("async_clr_RUN", 32'(RUN), 32'h0);
        check("async_clr_TC", 32'(TC), 32'h0);
        check("async_clr_DONE", 32'(DONE), 32'h0);
        m_secs  = 0;
        m_state = M_IDLE;
        exp_q.push_back(model_out(1'b0));
        @(negedge CP);
        CR = 1'b0;
    endtask

    // Monitor: compare every queued expectation one step after its edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CP);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("Q", {8'h0, Q_H, Q_M, Q_S}, {8'h0, e.h, e.m, e.s});
                check("RUN", 32'(RUN), 32'(e.run));
                check("TC", 32'(TC), 32'(e.tc));
                check("DONE", 32'(DONE), 32'(e.done));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [23:0] NO_LIM = 24'hFF_FF_FF;

    initial begin
        logic [23:0] lim, d;
        int          ahead, w;

        CR = 1'b1; CE = 1'b0; START = 1'b0; STOP = 1'b0; PE = 1'b0;
        {D_H, D_M, D_S} = 24'h0; {LIM_H, LIM_M, LIM_S} = NO_LIM;
        #3;
        check("reset_Q", {8'h0, Q_H, Q_M, Q_S}, 32'h0);
        check("reset_flags", {29'h0, RUN, TC, DONE}, 32'h0);
        @(negedge CP);
        CR = 1'b0;

        // Clear while running at 00:00:07.
        cycle(1, 0, 0, 0, 24'h00_00_00, NO_LIM);
        cycle(0, 0, 1, 0, 24'h0, NO_LIM);
        for (int i = 0; i < 7; i++) cycle(0, 0, 0, 1, 24'h0, NO_LIM);
        cr_pulse();

        // Reach limit 00:01:00 from 00:00:58.
        cycle(1, 0, 0, 0, 24'h00_00_58, 24'h00_01_00);
        cycle(0, 0, 1, 0, 24'h0, 24'h00_01_00);
        cycle(0, 0, 0, 1, 24'h0, 24'h00_01_00);
        cycle(0, 0, 0, 1, 24'h0, 24'h00_01_00);
        cycle(0, 0, 0, 1, 24'h0, 24'h00_01_00);
        cycle(0, 0, 0, 0, 24'h0, 24'h00_01_00);

        // Clear landing while TC is high.
        cycle(1, 0, 0, 0, 24'h00_00_58, 24'h00_01_00);
        cycle(0, 0, 1, 0, 24'h0, 24'h00_01_00);
        cycle(0, 0, 0, 1, 24'h0, 24'h00_01_00);
        cycle(0, 0, 0, 1, 24'h0, 24'h00_01_00);
        cr_pulse();

        // Day wrap with limit 00:00:00 and with an unreached limit.
        cycle(1, 0, 0, 0, 24'h23_59_59, 24'h00_00_00);
        cycle(0, 0, 1, 0, 24'h0, 24'h00_00_00);
        cycle(0, 0, 0, 1, 24'h0, 24'h00_00_00);
        cycle(1, 0, 0, 0, 24'h23_59_59, 24'h12_00_00);
        cycle(0, 0, 1, 0, 24'h0, 24'h12_00_00);
        cycle(0, 0, 0, 1, 24'h0, 24'h12_00_00);
        cycle(0, 0, 0, 0, 24'h0, 24'h12_00_00);

        // Pause holds the count; second STOP clears to IDLE.
        cycle(1, 0, 0, 0, 24'h00_00_10, NO_LIM);
        cycle(0, 0, 1, 0, 24'h0, NO_LIM);
        cycle(0, 1, 0, 0, 24'h0, NO_LIM);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 24'h0, NO_LIM);
        cycle(0, 1, 0, 0, 24'h0, NO_LIM);

        // START coinciding with CE does not count.
        cycle(1, 0, 0, 0, 24'h00_00_00, NO_LIM);
        cycle(0, 0, 1, 1, 24'h0, NO_LIM);
        cycle(0, 0, 0, 1, 24'h0, NO_LIM);

        // Invalid load fields, and load beating STOP.
        cycle(1, 0, 0, 0, 24'h05_61_7A, NO_LIM);
        cycle(0, 0, 1, 0, 24'h0, NO_LIM);
        cycle(1, 1, 0, 0, 24'h05_61_7A, NO_LIM);

        // Randomised traffic; limits are often placed a few ticks ahead to hit TC.
        lim = NO_LIM;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(299, 0) == 0) cr_pulse();
            w = $urandom_range(3, 0);
            if (w == 0) begin
                ahead = (m_secs + 1 + $urandom_range(4, 0)) % DAY;
                lim = {to_bcd(ahead / 3600), to_bcd((ahead / 60) % 60), to_bcd(ahead % 60)};
            end else if (w == 1 && $urandom_range(3, 0) == 0) begin
                lim = 24'($urandom);
            end
            if ($urandom_range(1, 0) == 0)
                d = 24'($urandom);
            else
                d = {to_bcd($urandom_range(23, 20)), to_bcd($urandom_range(59, 56)),
                     to_bcd($urandom_range(59, 50))};
            begin
                logic pe, stop, start, ce;
                pe    = ($urandom_range(24, 0) == 0);
                stop  = ($urandom_range(13, 0) == 0);
                start = !stop && ($urandom_range(7, 0) == 0);
                ce    = ($urandom_range(1, 0) == 0);
                cycle(pe, stop, start, ce, d, lim);
            end
        end

        // Drain the scoreboard with a bounded wait.
        begin
            int waited;
            waited = 0;
            while (exp_q.size() > 0 && waited < 20) begin
                @(negedge CP);
                waited++;
            end
            check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
